// File: rtl/evu_sched.sv
// evu_sched: time-multiplexes one 4-bit event mux across NUM_CTRS counters, round-robin over eligible counters.
// Define EVU_SCHED_OVF_IRQ_EN to add ovf_irq_o with a mask written through irq_mask_we_i/ovf_clr_i.
module evu_sched #(
  parameter int NUM_CTRS = 4,
  parameter int CNT_W = 32,
  parameter int WINDOW = 256,
  parameter int SETTLE = 2,
  localparam int IW = NUM_CTRS > 1 ? $clog2(NUM_CTRS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                debug_mode_i,
  input  logic                cfg_we_i,
  input  logic [IW-1:0]       cfg_idx_i,
  input  logic [3:0]          cfg_evt_i,
  input  logic                cfg_en_i,
  input  logic                cnt_we_i,
  input  logic [CNT_W-1:0]    cnt_wdata_i,
  input  logic [IW-1:0]       rd_idx_i,
  output logic [CNT_W-1:0]    rd_cnt_o,
  output logic [15:0]         rd_win_o,
  output logic [NUM_CTRS-1:0] ovf_o,
  input  logic [NUM_CTRS-1:0] ovf_clr_i,
  output logic [3:0]          sel_o,
  input  logic                evt_i,
`ifdef EVU_SCHED_OVF_IRQ_EN
  output logic                ovf_irq_o,
  input  logic                irq_mask_we_i,
`endif
  output logic [IW-1:0]       active_idx_o,
  output logic                busy_o
);
  localparam int TW = $clog2(WINDOW > SETTLE ? WINDOW : SETTLE);
  typedef enum logic [1:0] {IDLE, SELECT, SETTLING, SAMPLE} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [3:0] evt_q [NUM_CTRS];
  logic [CNT_W-1:0] cnt_q [NUM_CTRS];
  logic [15:0] win_q [NUM_CTRS];
  logic [NUM_CTRS-1:0] en_q, elig, wr, inc, win_inc;
  logic [IW-1:0] last, pick, j;
  logic found, in_slot, sampling, abort, done;

  // Round-robin search starts just after the last counter that completed a window.
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = '0;
    for (int k = 0; k < NUM_CTRS; k++) elig[k] = en_q[k] && evt_q[k] >= 4'h2;
    for (int k = 0; k < NUM_CTRS; k++) begin
      j = IW'((int'(last) + 1 + k) % NUM_CTRS);
      if (!found && elig[j]) begin
        found = 1'b1;
        pick = j;
      end
    end
  end

  assign in_slot = state == SETTLING || state == SAMPLE;
  assign busy_o = in_slot;
  assign sampling = !debug_mode_i && state == SAMPLE;
  assign abort = cfg_we_i && cfg_idx_i == active_idx_o && in_slot;
  assign done = sampling && en_i && !abort && timer == TW'(WINDOW - 1);
  assign wr = cnt_we_i ? (NUM_CTRS'(1) << cfg_idx_i) : '0;
  assign inc = (sampling && evt_i) ? ((NUM_CTRS'(1) << active_idx_o) & ~wr) : '0;
  assign win_inc = done ? ((NUM_CTRS'(1) << active_idx_o) & ~wr) : '0;
  assign rd_cnt_o = cnt_q[rd_idx_i];
  assign rd_win_o = win_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      timer <= '0;
      sel_o <= 4'h0;
      active_idx_o <= '0;
      last <= IW'(NUM_CTRS - 1);
    end else if (!debug_mode_i) begin
      if (!en_i) begin
        state <= IDLE;
        sel_o <= 4'h0;
      end else begin
        case (state)
          IDLE: state <= |elig ? SELECT : IDLE;
          SELECT: begin
            state <= found ? SETTLING : IDLE;
            sel_o <= found ? evt_q[pick] : 4'h0;
            active_idx_o <= found ? pick : active_idx_o;
            timer <= '0;
          end
          SETTLING: begin
            state <= abort ? SELECT : (timer == TW'(SETTLE - 1) ? SAMPLE : SETTLING);
            timer <= timer == TW'(SETTLE - 1) ? '0 : timer + 1'b1;
          end
          default: begin
            state <= (abort || timer == TW'(WINDOW - 1)) ? SELECT : SAMPLE;
            last <= done ? active_idx_o : last;
            timer <= timer + 1'b1;
          end
        endcase
      end
    end
  end

  // A counter write overrides any same-cycle increment and restarts its window tally.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (rst_i) begin
        evt_q[i] <= 4'h0;
        en_q[i] <= 1'b0;
        cnt_q[i] <= '0;
        win_q[i] <= '0;
        ovf_o[i] <= 1'b0;
      end else begin
        if (cfg_we_i && cfg_idx_i == IW'(i)) begin
          evt_q[i] <= cfg_evt_i;
          en_q[i] <= cfg_en_i;
        end
        if (wr[i]) begin
          cnt_q[i] <= cnt_wdata_i;
          win_q[i] <= '0;
        end else begin
          if (inc[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
          if (win_inc[i]) win_q[i] <= win_q[i] + 1'b1;
        end
        ovf_o[i] <= (ovf_o[i] && !ovf_clr_i[i]) || (inc[i] && &cnt_q[i]);
      end
    end
  end

`ifdef EVU_SCHED_OVF_IRQ_EN
  logic [NUM_CTRS-1:0] irq_mask;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_mask <= '0;
      ovf_irq_o <= 1'b0;
    end else begin
      if (irq_mask_we_i) irq_mask <= ovf_clr_i;
      ovf_irq_o <= |(ovf_o & irq_mask);
    end
  end
`endif
endmodule

// File: tb/tb_evu_sched.sv
// tb_evu_sched: randomized and directed checks of evu_sched against a slot-age behavioural model.
module tb_evu_sched;
  localparam int N = 4;
  localparam int WIN = 8;
  localparam int ST = 2;
  localparam int SLOT_END = ST + WIN - 1;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, dbg = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, cnt_we = 1'b0, evt = 1'b0;
  logic [1:0] cfg_idx = '0, rd_idx = '0;
  logic [3:0] cfg_evt = '0, ovf_clr = '0;
  logic [31:0] cnt_wdata = '0;
  logic [31:0] rd_cnt;
  logic [15:0] rd_win;
  logic [3:0] ovf, sel;
  logic [1:0] act;
  logic busy;

  evu_sched #(.NUM_CTRS(N), .CNT_W(32), .WINDOW(WIN), .SETTLE(ST)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .debug_mode_i(dbg),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_evt_i(cfg_evt), .cfg_en_i(cfg_en),
    .cnt_we_i(cnt_we), .cnt_wdata_i(cnt_wdata), .rd_idx_i(rd_idx),
    .rd_cnt_o(rd_cnt), .rd_win_o(rd_win), .ovf_o(ovf), .ovf_clr_i(ovf_clr),
    .sel_o(sel), .evt_i(evt), .active_idx_o(act), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_on = 0;

  // Model: mode 0 idle, 1 select, 2 in a slot whose age runs 0..ST+WIN-1 (sampling once age >= ST).
  logic [31:0] m_cnt [N];
  logic [15:0] m_win [N];
  logic [3:0] m_evt [N];
  bit m_en [N];
  logic [3:0] m_ovf, m_sel;
  int m_mode, m_age, m_act, m_last;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit samp, abort, done, found, any;
    int a, pick;
    logic [3:0] novf;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0; m_win[i] = 0; m_evt[i] = 0; m_en[i] = 0;
      end
      m_ovf = 0; m_sel = 0; m_mode = 0; m_age = 0; m_act = 0; m_last = N - 1;
      return;
    end
    a = m_act;
    samp = !dbg && m_mode == 2 && m_age >= ST;
    abort = m_mode == 2 && cfg_we && cfg_idx == a;
    done = samp && en && !abort && m_age == SLOT_END;
    if (!dbg) begin
      if (!en) begin
        m_mode = 0; m_sel = 0;
      end else if (m_mode == 0) begin
        any = 0;
        for (int i = 0; i < N; i++) if (m_en[i] && m_evt[i] >= 2) any = 1;
        if (any) m_mode = 1;
      end else if (m_mode == 1) begin
        found = 0; pick = 0;
        for (int k = 0; k < N; k++) begin
          int jj = (m_last + 1 + k) % N;
          if (!found && m_en[jj] && m_evt[jj] >= 2) begin found = 1; pick = jj; end
        end
        if (found) begin
          m_mode = 2; m_age = 0; m_act = pick; m_sel = m_evt[pick];
        end else begin
          m_mode = 0; m_sel = 0;
        end
      end else if (abort) m_mode = 1;
      else if (m_age == SLOT_END) begin
        m_mode = 1; m_last = a;
      end else m_age++;
    end
    novf = m_ovf & ~ovf_clr;
    if (samp && evt && !(cnt_we && cfg_idx == a)) begin
      if (m_cnt[a] == 32'hFFFF_FFFF) novf[a] = 1'b1;
      m_cnt[a]++;
    end
    if (done && !(cnt_we && cfg_idx == a)) m_win[a]++;
    if (cnt_we) begin m_cnt[cfg_idx] = cnt_wdata; m_win[cfg_idx] = 0; end
    if (cfg_we) begin m_evt[cfg_idx] = cfg_evt; m_en[cfg_idx] = cfg_en; end
    m_ovf = novf;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_on) begin
      check("sel", sel, m_sel);
      check("busy", busy, m_mode == 2);
      check("act", act, m_act);
      check("ovf", ovf, m_ovf);
      check("rd_cnt", rd_cnt, m_cnt[rd_idx]);
      check("rd_win", rd_win, m_win[rd_idx]);
    end
  end

  task automatic rdchk(string n, int i, logic [31:0] ec, logic [15:0] ew);
    rd_idx = 2'(i);
    #1;
    check({n, "_cnt"}, rd_cnt, ec);
    check({n, "_win"}, rd_win, ew);
  endtask

  task automatic cfg(int i, int e, bit b);
    cfg_we = 1; cfg_idx = 2'(i); cfg_evt = 4'(e); cfg_en = b;
    tick();
    cfg_we = 0;
  endtask

  initial begin
    rst = 1; tick(); rst = 0; chk_on = 1;
    check("rst_sel", sel, 0); check("rst_busy", busy, 0); check("rst_ovf", ovf, 0); check("rst_act", act, 0);
    for (int i = 0; i < N; i++) rdchk("rst", i, 0, 0);
    // basic slot: ctr1 on event 3, evt_i held high
    en = 1; evt = 1;
    cfg(1, 3, 1);
    tick(); check("sel_state_busy", busy, 0);
    tick(); check("basic_sel", sel, 3); check("basic_act", act, 1); check("basic_busy", busy, 1);
    tick(); tick(); rdchk("settle_ignored", 1, 0, 0);
    repeat (8) tick();
    rdchk("basic_done", 1, 8, 1);
    en = 0; tick(); check("dis_sel", sel, 0); check("dis_busy", busy, 0);
    rst = 1; tick(); rst = 0;
    // round-robin with overflow on ctr0
    cfg(0, 2, 1); cfg(2, 5, 1); cfg(3, 1, 1);
    cnt_we = 1; cfg_idx = 0; cnt_wdata = 32'hFFFF_FFFE; tick(); cnt_we = 0;
    en = 1; tick(); tick();
    check("rr_sel0", sel, 2); check("rr_act0", act, 0);
    tick(); tick(); tick(); tick();
    rdchk("ovf_wrap", 0, 0, 0); check("ovf_set", ovf, 4'b0001);
    ovf_clr = 4'b0001; tick(); ovf_clr = 0;
    check("ovf_clr", ovf, 0);
    repeat (5) tick();
    rdchk("rr_ctr0", 0, 6, 1);
    tick(); check("rr_sel1", sel, 5); check("rr_act1", act, 2);
    repeat (10) tick();
    tick(); check("rr_sel2", sel, 2); check("rr_act2", act, 0);
    rdchk("rr_ctr1_untouched", 1, 0, 0);
    rdchk("rr_ctr3_untouched", 3, 0, 0);
    // abort: reconfigure ctr0 mid-sample
    repeat (5) tick();
    cfg(0, 4, 1);
    check("abort_busy", busy, 0); rdchk("abort", 0, 10, 1);
    tick(); check("abort_sel", sel, 4); check("abort_act", act, 0);
    repeat (4) tick();
    rdchk("dbg_pre", 0, 12, 1);
    dbg = 1;
    repeat (5) begin
      tick(); check("dbg_cnt", rd_cnt, 12); check("dbg_sel", sel, 4); check("dbg_busy", busy, 1);
    end
    dbg = 0;
    repeat (5) tick();
    rdchk("dbg_run", 0, 17, 1); check("dbg_run_busy", busy, 1);
    tick(); rdchk("dbg_done", 0, 18, 2); check("dbg_done_busy", busy, 0);
    // reset mid-sample
    repeat (5) tick();
    check("pre_rst_busy", busy, 1);
    rst = 1; tick(); rst = 0;
    check("mid_rst_sel", sel, 0); check("mid_rst_busy", busy, 0);
    for (int i = 0; i < N; i++) rdchk("mid_rst", i, 0, 0);
    tick(); tick(); check("mid_rst_idle", busy, 0);
    // randomized phase
    repeat (4000) begin
      rst = $urandom_range(0, 599) == 0;
      en = $urandom_range(0, 30) != 0;
      dbg = $urandom_range(0, 9) == 0;
      evt = 1'($urandom);
      cfg_we = $urandom_range(0, 11) == 0;
      cfg_idx = 2'($urandom);
      cfg_evt = 4'($urandom);
      cfg_en = $urandom_range(0, 3) != 0;
      cnt_we = $urandom_range(0, 39) == 0;
      cnt_wdata = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFFF - $urandom_range(0, 10);
      ovf_clr = $urandom_range(0, 19) == 0 ? 4'($urandom) : 4'h0;
      rd_idx = 2'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
